spi_tx_arbiter: RTL and testbench
=================================

// Module: spi_tx_arbiter
// PURPOSE
//  Shares one SPI-mode-0, LSB-first byte transmitter between N_REQ requesters.
//  Contains the arbiter, frame sequencer FSM, SCLK divider and shift register.
//  Sits between the on-chip byte sources and the external SPI slave pins.
// PARAMETERS
//  N_REQ    4   number of requesters (>=1)
//  DATA_W   8   bits per frame (>=1)
//  CLK_DIV  16  clk cycles per SCLK half-period (>=1)
// PORTS
//  clk      in   1               system clock, all logic on posedge
//  reset    in   1               asynchronous, active-high; clears all state
//  req      in   N_REQ           req[i]=1: requester i has a byte pending
//  data     in   N_REQ*DATA_W    byte of requester i at data[i*DATA_W +: DATA_W]
//  ack      out  N_REQ           one-hot, 1-cycle pulse: byte of req i captured
//  done     out  1               1-cycle pulse: frame finished, CS deasserted
//  done_id  out  clog2(N_REQ)    requester index of finished frame, valid with done
//  busy     out  1               high from ack cycle through done cycle inclusive
//  sclk     out  1               SPI clock, idles low
//  cs_n     out  1               SPI chip select, active low
//  mosi     out  1               SPI data out
// BEHAVIOUR
//  Reset values: ack=0, done=0, done_id=0, busy=0, sclk=0, cs_n=1, mosi=0;
//  FSM=IDLE, RR pointer=0. Reset mid-frame aborts immediately; no done pulse.
//  Handshake: requester holds req high and data stable until ack; ack'ed byte
//  latched into shift reg in the ack cycle; requester may drop req after ack.
//  req dropped before ack -> nothing sent. req changes during a frame ignored.
//  Arbitration only in IDLE, only when |req; ack and IDLE->SETUP same cycle.
//  Round robin: search starts at RR pointer; after grant to i, pointer=(i+1)%N_REQ.
//  FSM states, each timed by a CLK_DIV-cycle divider counter:
//   IDLE : cs_n=1, sclk=0. On |req -> SETUP.
//   SETUP: cs_n=0, mosi=bit0, CLK_DIV cycles -> SHIFT.
//   SHIFT: DATA_W SCLK periods; sclk rises after CLK_DIV cycles (slave samples),
//          falls after 2*CLK_DIV; on each fall except last, shift reg rotates
//          right and mosi=next bit (LSB first). After last fall -> HOLD.
//   HOLD : cs_n=0, sclk=0, CLK_DIV cycles -> GAP.
//   GAP  : cs_n=1, CLK_DIV cycles; done+done_id pulse in last GAP cycle -> IDLE.
//  Frame length ack->done inclusive: (2*DATA_W+3)*CLK_DIV cycles
//  (defaults: 304). At least one IDLE cycle between frames, so next ack comes
//  no earlier than 1 cycle after done.
//  mosi driven 0 outside SETUP/SHIFT. sclk,cs_n,mosi are registered (glitch-free).
//  N_REQ=1: pointer fixed at 0, done_id width 1 and always 0.
// CONFIGURATION
//  SPI_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; RR
//  pointer removed. Undefined (default): round robin as above.
// TESTING
//  T1 reset, req=4'b0001, data0=8'hA5 -> ack[0] next edge; mosi bits
//     1,0,1,0,0,1,0,1 on 8 sclk rises; done, done_id=0 after 304 cycles.
//  T2 req=4'b1111 held -> grants in order 0,1,2,3,0; with
//     SPI_ARB_FIXED_PRIO_EN -> 0,0,0 while req[0] stays high.
//  T3 req[2] pulsed 1 cycle while busy -> no ack[2]; frame timing unchanged.
//  T4 reset asserted mid-SHIFT -> same cycle cs_n=1, sclk=0, mosi=0, busy=0;
//     no done; after release req[1] -> ack[1] (pointer reset to 0).
//  T5 CLK_DIV=1, DATA_W=8, data=8'hFF -> sclk toggles every cycle, 8 rises
//     with mosi=1, cs_n low 18 cycles, done at cycle 19 after ack.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// Shared SPI mode-0, LSB-first byte transmitter with N_REQ-way arbitration.
// Build option: define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module spi_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 16,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
  output logic                    busy,
  output logic                    sclk,
  output logic                    cs_n,
  output logic                    mosi
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                cnt_last;
  logic [BIT_W-1:0]    bit_idx, bit_nxt;
  logic [DATA_W-1:0]   shreg, sh_nxt, sh_rot, sel_data;
  logic                sclk_nxt, cs_n_nxt, mosi_nxt;
  logic [N_REQ-1:0]    ack_nxt;
  logic [ID_W-1:0]     cur_id, id_nxt;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;

  function automatic logic [DATA_W-1:0] rotate_right(input logic [DATA_W-1:0] v);
    return (v >> 1) | (v << (DATA_W - 1));
  endfunction

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;

  // Scan downward so the candidate closest to the pointer is assigned last and wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (state == IDLE && grant_vld) begin
      ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end
`endif

  assign sel_data = data[int'(grant_idx)*DATA_W +: DATA_W];
  assign sh_rot   = rotate_right(shreg);
  assign cnt_last = (cnt == CNT_LAST);

  // Next-state logic; pin outputs are computed for the state being entered.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_last ? '0 : cnt + CNT_W'(1);
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    sclk_nxt  = 1'b0;
    cs_n_nxt  = 1'b1;
    mosi_nxt  = 1'b0;
    ack_nxt   = '0;
    id_nxt    = cur_id;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (grant_vld) begin
          state_nxt          = SETUP;
          cs_n_nxt           = 1'b0;
          sh_nxt             = sel_data;
          mosi_nxt           = sel_data[0];
          ack_nxt[grant_idx] = 1'b1;
          id_nxt             = grant_idx;
        end
      end
      SETUP: begin
        cs_n_nxt = 1'b0;
        mosi_nxt = mosi;
        if (cnt_last) begin
          state_nxt = SHIFT;
          bit_nxt   = '0;
        end
      end
      SHIFT: begin
        cs_n_nxt = 1'b0;
        sclk_nxt = sclk;
        mosi_nxt = mosi;
        if (cnt_last) begin
          if (!sclk) begin
            sclk_nxt = 1'b1;
          end else begin
            sclk_nxt = 1'b0;
            if (bit_idx == BIT_LAST) begin
              state_nxt = HOLD;
              mosi_nxt  = 1'b0;
            end else begin
              bit_nxt  = bit_idx + BIT_W'(1);
              sh_nxt   = sh_rot;
              mosi_nxt = sh_rot[0];
            end
          end
        end
      end
      HOLD: begin
        cs_n_nxt = cnt_last;
        if (cnt_last) state_nxt = GAP;
      end
      GAP: begin
        if (cnt_last) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      ack     <= '0;
      cur_id  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
      sclk    <= sclk_nxt;
      cs_n    <= cs_n_nxt;
      mosi    <= mosi_nxt;
      ack     <= ack_nxt;
      cur_id  <= id_nxt;
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == GAP) && cnt_last;
  assign done_id = done ? cur_id : '0;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: per-cycle frame-timeline model, vector table and corner sequences.
module tb_spi_tx_arbiter;
  localparam int N = 4;
  localparam int D = 8;
  localparam int C = 16;
  localparam int L = (2*D + 3) * C;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*D-1:0] data = '0;
  logic [N-1:0] ack;
  logic         done, busy, sclk, cs_n, mosi;
  logic [1:0]   done_id;

  logic [N-1:0] req_f = '0;
  logic [N*D-1:0] data_f = '0;
  logic [N-1:0] ack_f;
  logic         done_f, busy_f, sclk_f, cs_n_f, mosi_f;
  logic [1:0]   done_id_f;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_tx_arbiter #(.N_REQ(N), .DATA_W(D), .CLK_DIV(C)) u_dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack), .done(done),
    .done_id(done_id), .busy(busy), .sclk(sclk), .cs_n(cs_n), .mosi(mosi));

  spi_tx_arbiter #(.N_REQ(N), .DATA_W(D), .CLK_DIV(1)) u_fast (
    .clk(clk), .reset(reset), .req(req_f), .data(data_f), .ack(ack_f), .done(done_f),
    .done_id(done_id_f), .busy(busy_f), .sclk(sclk_f), .cs_n(cs_n_f), .mosi(mosi_f));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a frame is a fixed timeline measured from the ack cycle.
  function automatic int model_grant(input logic [N-1:0] r, input int ptr);
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return 0;
  endfunction

  function automatic logic [10:0] model_out(input bit act, input int o, input int id,
                                            input logic [D-1:0] b);
    logic [3:0] a;
    logic dn, bs, sc, cs, mo;
    logic [1:0] did;
    int s;
    a = '0; dn = 0; did = '0; bs = 0; sc = 0; cs = 1; mo = 0; s = 0;
    if (act) begin
      bs = 1;
      if (o == 0) a = 4'(1 << id);
      if (o < (2*D + 2) * C) cs = 0;
      if (o < C) begin
        mo = b[0];
      end else if (o < C + 2*D*C) begin
        s  = o - C;
        mo = b[s / (2*C)];
        sc = (s % (2*C)) >= C;
      end
      if (o == L - 1) begin
        dn  = 1;
        did = 2'(id);
      end
    end
    return {a, dn, did, bs, sc, cs, mo};
  endfunction

  logic [N-1:0]   req_pe = '0;
  logic [N*D-1:0] data_pe = '0;
  logic           rst_pe = 1'b1;

  initial forever begin
    @(posedge clk);
    req_pe = req;
    data_pe = data;
    rst_pe = reset;
  end

  bit         m_act = 0;
  int         m_o = 0, m_id = 0, m_ptr = 0;
  logic [D-1:0] m_byte = '0;

  initial forever begin
    logic [10:0] exp_v, got_v;
    bit prev_idle;
    @(negedge clk);
    if (reset) begin
      m_act = 0;
      m_ptr = 0;
    end else begin
      prev_idle = !m_act;
      if (m_act) begin
        m_o++;
        if (m_o == L) m_act = 0;
      end
      if (prev_idle && !rst_pe && req_pe != '0) begin
        m_id   = model_grant(req_pe, m_ptr);
        m_ptr  = (m_id + 1) % N;
        m_byte = data_pe[m_id*D +: D];
        m_act  = 1;
        m_o    = 0;
      end
    end
    exp_v = model_out(m_act, m_o, m_id, m_byte);
    got_v = {ack, done, done_id, busy, sclk, cs_n, mosi};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t: got %b expected %b (ack,done,id,busy,sclk,cs_n,mosi)",
               $time, got_v, exp_v);
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_ack(input int limit, output logic [N-1:0] a, output int cyc);
    a = '0; cyc = 0;
    while (a == '0 && cyc < limit) begin
      @(negedge clk); cyc++; a = ack;
    end
  endtask

  task automatic wait_done(input int limit, output logic seen, output logic [1:0] id,
                           output int cyc);
    seen = 0; id = '0; cyc = 0;
    while (!seen && cyc < limit) begin
      @(negedge clk); cyc++; seen = done; id = done_id;
    end
  endtask

  // Called in the ack cycle; follows the frame to done, optionally pulsing req once.
  task automatic watch_frame(input int pulse_at, input logic [N-1:0] pulse_r,
                             output int len, output logic [D-1:0] cap, output int rises,
                             output int extra, output logic seen, output logic [1:0] id);
    logic prev;
    len = 1; cap = '0; rises = 0; extra = 0; seen = 0; id = '0; prev = sclk;
    while (!seen && len < L + 20) begin
      req = (len == pulse_at) ? pulse_r : '0;
      @(negedge clk); len++;
      if (ack != '0) extra++;
      if (sclk && !prev) begin
        if (rises < D) cap[rises] = mosi;
        rises++;
      end
      prev = sclk; seen = done; id = done_id;
    end
    req = '0;
  endtask

  typedef struct {
    logic [N-1:0]   r;
    logic [N*D-1:0] d;
    int             exp_id;
  } vec_t;

`ifdef SPI_ARB_FIXED_PRIO_EN
  localparam int EXP_ID [8] = '{0, 0, 0, 3, 1, 1, 0, 2};
  localparam int T2_ID  [5] = '{0, 0, 0, 0, 0};
`else
  localparam int EXP_ID [8] = '{0, 2, 0, 3, 1, 2, 3, 2};
  localparam int T2_ID  [5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    vec_t tbl [8];
    logic [N-1:0] a;
    logic [D-1:0] cap;
    logic [1:0]   id;
    logic         seen, prev, tog_ok;
    int cyc, len, rises, extra, lows, ones;

    tbl[0] = '{4'b0001, 32'h4433_22A5, EXP_ID[0]};
    tbl[1] = '{4'b0101, 32'h1C3C_5A7E, EXP_ID[1]};
    tbl[2] = '{4'b0011, 32'h0F0F_8001, EXP_ID[2]};
    tbl[3] = '{4'b1000, 32'hC300_0000, EXP_ID[3]};
    tbl[4] = '{4'b1010, 32'h99FF_6600, EXP_ID[4]};
    tbl[5] = '{4'b0110, 32'h00B4_2D00, EXP_ID[5]};
    tbl[6] = '{4'b1111, 32'h8142_2418, EXP_ID[6]};
    tbl[7] = '{4'b1100, 32'h55AA_3311, EXP_ID[7]};

    @(negedge clk);
    chk("reset_vals", {ack, done, done_id, busy, sclk, cs_n, mosi}, 11'b0000_0_00_0_0_1_0);
    chk("reset_vals_fast", {ack_f, done_f, done_id_f, busy_f, sclk_f, cs_n_f, mosi_f},
        11'b0000_0_00_0_0_1_0);
    @(negedge clk); #2 reset = 1'b0;

    // T1: single byte A5 from requester 0.
    @(negedge clk); req = 4'b0001; data = 32'h7E3C_18A5;
    wait_ack(20, a, cyc);
    chk("t1_ack", a, 4'b0001);
    chk("t1_ack_latency", cyc, 1);
    watch_frame(0, '0, len, cap, rises, extra, seen, id);
    chk("t1_mosi_bits", cap, 8'hA5);
    chk("t1_rises", rises, D);
    chk("t1_len", len, L);
    chk("t1_done_id", {seen, id}, 3'b100);

    // Vector table, starting from a freshly reset pointer.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req = tbl[i].r; data = tbl[i].d;
      wait_ack(20, a, cyc);
      chk($sformatf("tbl%0d_ack", i), a, 32'(1 << tbl[i].exp_id));
      req = '0;
      wait_done(L + 10, seen, id, cyc);
      chk($sformatf("tbl%0d_done", i), seen, 1);
      chk($sformatf("tbl%0d_done_id", i), id, tbl[i].exp_id);
      chk($sformatf("tbl%0d_len", i), cyc + 1, L);
    end

    // T2: all requesters held high.
    do_reset();
    @(negedge clk); req = 4'b1111; data = 32'hD4C3_B2A1;
    for (int i = 0; i < 5; i++) begin
      wait_ack(L + 20, a, cyc);
      chk($sformatf("t2_grant%0d", i), a, 32'(1 << T2_ID[i]));
      if (i == 4) req = '0;
      wait_done(L + 10, seen, id, cyc);
      chk($sformatf("t2_done_id%0d", i), id, T2_ID[i]);
    end

    // T3: a one-cycle req[2] pulse mid-frame is ignored.
    do_reset();
    @(negedge clk); req = 4'b0001; data = 32'h0000_00C6;
    wait_ack(20, a, cyc);
    chk("t3_ack", a, 4'b0001);
    watch_frame(50, 4'b0100, len, cap, rises, extra, seen, id);
    chk("t3_no_extra_ack", extra, 0);
    chk("t3_len", len, L);
    chk("t3_byte", cap, 8'hC6);
    repeat (3) @(negedge clk);
    chk("t3_idle_after", {ack, busy}, 5'b0);

    // T4: asynchronous reset in the middle of SHIFT.
    do_reset();
    @(negedge clk); req = 4'b0010; data = 32'h0000_3C00;
    wait_ack(20, a, cyc);
    chk("t4_first_ack", a, 4'b0010);
    req = '0;
    repeat (100) @(negedge clk);
    chk("t4_in_frame", {busy, cs_n}, 2'b10);
    @(posedge clk); #3 reset = 1'b1;
    #1 chk("t4_async_clear", {ack, done, busy, sclk, cs_n, mosi}, 9'b0000_0_0_0_1_0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk); req = 4'b0110; data = 32'h0000_9900;
    wait_ack(20, a, cyc);
    chk("t4_ack_after_reset", a, 4'b0010);
    req = '0;
    wait_done(L + 10, seen, id, cyc);
    chk("t4_done_id", {seen, id}, 3'b101);

    // T5: CLK_DIV=1 instance, byte FF.
    @(negedge clk); req_f = 4'b0001; data_f = 32'h0000_00FF;
    a = '0; cyc = 0;
    while (a == '0 && cyc < 20) begin
      @(negedge clk); cyc++; a = ack_f;
    end
    chk("t5_ack", a, 4'b0001);
    req_f = '0;
    len = 1; lows = cs_n_f ? 0 : 1; rises = 0; ones = 0; tog_ok = 1; prev = sclk_f; seen = 0;
    while (!seen && len < 40) begin
      @(negedge clk); len++;
      if (!cs_n_f) lows++;
      if (sclk_f && !prev) begin
        rises++;
        if (mosi_f) ones++;
      end
      if (len >= 3 && len <= 17 && sclk_f == prev) tog_ok = 0;
      prev = sclk_f; seen = done_f;
    end
    chk("t5_rises", rises, 8);
    chk("t5_mosi_ones", ones, 8);
    chk("t5_cs_low", lows, 18);
    chk("t5_done_cycle", len, 19);
    chk("t5_toggle", tog_ok, 1);
    chk("t5_done_id", done_id_f, 0);

    // Randomized traffic against the timeline model.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      req  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      data = $urandom;
    end
    @(negedge clk); req = '0;
    repeat (L + 5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
